udp_tx_arbiter: RTL

- Shares one UDP transmit engine between two byte-stream requesters: requester 0 carries command replies, requester 1 carries telemetry.
- Grants requesters round-robin and fetches bytes from the granted requester's read-latency-1 FIFO.
- Packs bytes into 32-bit words, first byte in [31:24], which is the inverse of the receive-side byte swap.
- Sequences the engine's request/ack/done handshake with destination port and byte length.

---
 rtl/udp_tx_arbiter_if.sv | 26 ++
 rtl/udp_tx_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter_if.sv
// udp_tx_arbiter_if: requester FIFO/request bundle plus UDP engine handshake around udp_tx_arbiter.
// master is the arbiter side; slave is the requesters and the engine together.
interface udp_tx_arbiter_if;
  logic [1:0]  req_valid;
  logic [31:0] req_len;
  logic [31:0] req_port;
  logic [1:0]  req_rd;
  logic [15:0] req_byte;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic        udp_tx_req;
  logic        udp_tx_ack;
  logic [15:0] udp_tx_dst_port;
  logic [15:0] udp_tx_len;
  logic [31:0] udp_tx_data;
  logic        udp_tx_data_en;
  logic        udp_tx_done;
  modport master (
    input  req_valid, req_len, req_port, req_byte, udp_tx_ack, udp_tx_done,
    output req_rd, req_done, req_err, udp_tx_req, udp_tx_dst_port, udp_tx_len, udp_tx_data, udp_tx_data_en
  );
  modport slave (
    output req_valid, req_len, req_port, req_byte, udp_tx_ack, udp_tx_done,
    input  req_rd, req_done, req_err, udp_tx_req, udp_tx_dst_port, udp_tx_len, udp_tx_data, udp_tx_data_en
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin share of one UDP transmit engine between two byte-stream requesters.
// Define UDP_TX_TIMEOUT_EN to abort frames whose engine request is not acked within TIMEOUT cycles.
module udp_tx_arbiter #(
  parameter int MAX_LEN = 1472,
  parameter int GAP = 8
`ifdef UDP_TX_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic             Clk,
  input  logic             Rst,
  udp_tx_arbiter_if.master bus,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, ARB, REJECT, WAIT_ACK, XFER, WAIT_DONE, GAP_ST} state_t;
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  localparam logic [15:0] GAP_L = 16'(GAP);
  state_t      state_q;
  logic        g_q, last_q, rvld_q, done_seen_q, tx_req_q, data_en_q;
  logic [1:0]  rd_q, done_q, err_q;
  logic [15:0] len_q, port_q, rd_cnt_q, rx_cnt_q, gap_q;
  logic [31:0] pack_q, data_q;
  logic        g_d, rx_last_d, full_d;
  logic [15:0] len_d, port_d;
  logic [7:0]  byte_d;
  logic [31:0] word_d;
`ifdef UDP_TX_TIMEOUT_EN
  localparam logic [15:0] TO_L = 16'(TIMEOUT);
  logic [15:0] to_q;
`endif
  // last_q names the requester served last, so a tie goes to the other one
  always_comb begin
    g_d = &bus.req_valid ? ~last_q : bus.req_valid[1];
    len_d = g_d ? bus.req_len[31:16] : bus.req_len[15:0];
    port_d = g_d ? bus.req_port[31:16] : bus.req_port[15:0];
    byte_d = g_q ? bus.req_byte[15:8] : bus.req_byte[7:0];
    word_d = pack_q | ({byte_d, 24'h0} >> {rx_cnt_q[1:0], 3'b000});
    rx_last_d = rx_cnt_q + 16'd1 == len_q;
    full_d = &rx_cnt_q[1:0] | rx_last_d;
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state_q <= IDLE;
      g_q <= 1'b0;
      last_q <= 1'b1;
      rvld_q <= 1'b0;
      done_seen_q <= 1'b0;
      tx_req_q <= 1'b0;
      data_en_q <= 1'b0;
      rd_q <= 2'b00;
      done_q <= 2'b00;
      err_q <= 2'b00;
      len_q <= 16'd0;
      port_q <= 16'd0;
      rd_cnt_q <= 16'd0;
      rx_cnt_q <= 16'd0;
      gap_q <= 16'd0;
      pack_q <= 32'h0;
      data_q <= 32'h0;
`ifdef UDP_TX_TIMEOUT_EN
      to_q <= 16'd0;
`endif
    end else begin
      done_q <= 2'b00;
      err_q <= 2'b00;
      data_en_q <= 1'b0;
      case (state_q)
        IDLE: if (|bus.req_valid) state_q <= ARB;
        ARB: begin
          g_q <= g_d;
          len_q <= len_d;
          port_q <= port_d;
`ifdef UDP_TX_TIMEOUT_EN
          to_q <= 16'd0;
`endif
          if (~|bus.req_valid) state_q <= IDLE;
          else if (len_d == 16'd0 || len_d > MAX_L) begin
            state_q <= REJECT;
            done_q <= {g_d, ~g_d};
            err_q <= {g_d, ~g_d};
          end else begin
            state_q <= WAIT_ACK;
            tx_req_q <= 1'b1;
          end
        end
        REJECT: state_q <= IDLE;
        WAIT_ACK: begin
          if (bus.udp_tx_ack) begin
            state_q <= XFER;
            tx_req_q <= 1'b0;
            rd_q <= {g_q, ~g_q};
            rd_cnt_q <= 16'd1;
            rx_cnt_q <= 16'd0;
            rvld_q <= 1'b0;
            pack_q <= 32'h0;
            done_seen_q <= 1'b0;
          end
`ifdef UDP_TX_TIMEOUT_EN
          else if (to_q == TO_L - 16'd1) begin
            state_q <= GAP_ST;
            tx_req_q <= 1'b0;
            done_q <= {g_q, ~g_q};
            err_q <= {g_q, ~g_q};
            last_q <= g_q;
            gap_q <= GAP_L;
          end else to_q <= to_q + 16'd1;
`endif
        end
        XFER: begin
          rd_q <= rd_cnt_q != len_q ? {g_q, ~g_q} : 2'b00;
          rd_cnt_q <= rd_cnt_q + {15'd0, rd_cnt_q != len_q};
          rvld_q <= |rd_q;
          if (bus.udp_tx_done) done_seen_q <= 1'b1;
          // rvld_q marks the cycle a byte strobed last cycle is on req_byte
          if (rvld_q) begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
            pack_q <= full_d ? 32'h0 : word_d;
            if (full_d) begin
              data_q <= word_d;
              data_en_q <= 1'b1;
            end
            if (rx_last_d) state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: if (bus.udp_tx_done || done_seen_q) begin
          state_q <= GAP_ST;
          done_q <= {g_q, ~g_q};
          last_q <= g_q;
          gap_q <= GAP_L;
          done_seen_q <= 1'b0;
        end
        GAP_ST: if (gap_q <= 16'd1) state_q <= IDLE; else gap_q <= gap_q - 16'd1;
        default: state_q <= IDLE;
      endcase
    end
  assign bus.req_rd = rd_q;
  assign bus.req_done = done_q;
  assign bus.req_err = err_q;
  assign bus.udp_tx_req = tx_req_q;
  assign bus.udp_tx_dst_port = port_q;
  assign bus.udp_tx_len = len_q;
  assign bus.udp_tx_data = data_q;
  assign bus.udp_tx_data_en = data_en_q;
  assign busy = state_q != IDLE;
endmodule
